// File: rtl/neuron_sweep_ctrl.sv
// neuron_sweep_ctrl: sequencer that runs read-modify-write sweeps over the if_neuron state SRAM
//
// Drives the combinational neuron datapath for three jobs: a pre-synaptic input event (SW_EVT),
// time-step evaluation (SW_TS) and time-reference clear (SW_REF). Spikes produced by time-step
// sweeps are queued in an output FIFO.
//
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   evt_valid_i/evt_ready_o/evt_pre_addr_i input event handshake and its pre-synaptic index
//   ts_req_i, ref_req_i                   one-cycle job requests (time step, time reference)
//   busy_o                                sweep running or request pending
//   nrn_re_o/nrn_raddr_o/nrn_rdata_i      neuron SRAM read port (data one cycle after re)
//   nrn_we_o/nrn_waddr_o/nrn_wdata_o      neuron SRAM write port
//   syn_re_o/syn_addr_o/syn_rdata_i       weight SRAM read port (data one cycle after re)
//   n_*_o                                 operands and one-hot job strobes to the neuron
//   n_*_i                                 results from the neuron
//   spk_valid_o/spk_ready_i/spk_addr_o    output spike FIFO (post index of spiking neuron)
module neuron_sweep_ctrl #(
    parameter int N_POST         = 256,
    parameter int POST_AW        = 8,
    parameter int PRE_AW         = 8,
    parameter int SPK_FIFO_DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      evt_valid_i,
    output logic                      evt_ready_o,
    input  logic [PRE_AW-1:0]         evt_pre_addr_i,
    input  logic                      ts_req_i,
    input  logic                      ref_req_i,
    output logic                      busy_o,
    output logic                      nrn_re_o,
    output logic [POST_AW-1:0]        nrn_raddr_o,
    input  logic [18:0]               nrn_rdata_i,
    output logic                      nrn_we_o,
    output logic [POST_AW-1:0]        nrn_waddr_o,
    output logic [18:0]               nrn_wdata_o,
    output logic                      syn_re_o,
    output logic [PRE_AW+POST_AW-1:0] syn_addr_o,
    input  logic [7:0]                syn_rdata_i,
    output logic [11:0]               n_state_core_o,
    output logic [6:0]                n_post_cnt_o,
    output logic [7:0]                n_syn_weight_o,
    output logic                      n_neuron_event_o,
    output logic                      n_time_step_event_o,
    output logic                      n_time_ref_event_o,
    input  logic [11:0]               n_state_core_next_i,
    input  logic [6:0]                n_post_cnt_next_i,
    input  logic                      n_spike_out_i,
    output logic                      spk_valid_o,
    input  logic                      spk_ready_i,
    output logic [POST_AW-1:0]        spk_addr_o
);
    localparam int FAW = $clog2(SPK_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SW_EVT, SW_TS, SW_REF} state_t;

    state_t             state_q, state_d;
    logic [POST_AW-1:0] idx_q, idx_d, s1_idx_q;
    logic               issued_q, issued_d, s1_valid_q;
    logic               ts_pend_q, ts_pend_d, ref_pend_q, ref_pend_d;
    logic [PRE_AW-1:0]  pre_q;
    logic [POST_AW-1:0] fifo_q [SPK_FIFO_DEPTH];
    logic [FAW-1:0]     wptr_q, rptr_q;
    logic [FAW:0]       cnt_q;
    logic               idle, issue, room, hs, push, pop;

    assign idle  = state_q == IDLE;
    // Reserve a FIFO slot for the word already in S1 so a spike can never be dropped.
    assign room  = (cnt_q + (FAW+1)'(s1_valid_q)) < (FAW+1)'(SPK_FIFO_DEPTH);
    assign issue = ~idle & ~issued_q & (state_q != SW_TS | room);
    assign hs    = evt_valid_i & evt_ready_o;
    assign push  = s1_valid_q & state_q == SW_TS & n_spike_out_i;
    assign pop   = spk_ready_i & spk_valid_o;

    assign evt_ready_o = idle & ~ts_pend_q & ~ref_pend_q & ~ts_req_i & ~ref_req_i;
    assign busy_o      = ~idle | ts_pend_q | ref_pend_q;

    assign nrn_re_o    = issue;
    assign nrn_raddr_o = idx_q;
    assign syn_re_o    = issue & state_q == SW_EVT;
    assign syn_addr_o  = {pre_q, idx_q};

    assign nrn_we_o            = s1_valid_q;
    assign nrn_waddr_o         = s1_idx_q;
    assign nrn_wdata_o         = s1_valid_q ? {n_post_cnt_next_i, n_state_core_next_i} : '0;
    assign n_state_core_o      = s1_valid_q ? nrn_rdata_i[11:0] : '0;
    assign n_post_cnt_o        = s1_valid_q ? nrn_rdata_i[18:12] : '0;
    assign n_syn_weight_o      = s1_valid_q & state_q == SW_EVT ? syn_rdata_i : '0;
    assign n_neuron_event_o    = s1_valid_q & state_q == SW_EVT;
    assign n_time_step_event_o = s1_valid_q & state_q == SW_TS;
    assign n_time_ref_event_o  = s1_valid_q & state_q == SW_REF;

    assign spk_valid_o = cnt_q != '0;
    assign spk_addr_o  = spk_valid_o ? fifo_q[rptr_q] : '0;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        issued_d   = issued_q;
        ts_pend_d  = ts_pend_q | ts_req_i;
        ref_pend_d = ref_pend_q | ref_req_i;
        if (idle) begin
            idx_d    = '0;
            issued_d = 1'b0;
            if (ref_pend_q) begin
                state_d    = SW_REF;
                ref_pend_d = ref_req_i;
            end else if (ts_pend_q) begin
                state_d   = SW_TS;
                ts_pend_d = ts_req_i;
            end else if (hs) begin
                state_d = SW_EVT;
            end
        end else begin
            if (issue) begin
                idx_d    = idx_q + POST_AW'(1);
                issued_d = idx_q == POST_AW'(N_POST-1);
            end
            // Once the last index has been issued, S1 writes it back this cycle.
            if (issued_q) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            issued_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            ts_pend_q  <= 1'b0;
            ref_pend_q <= 1'b0;
            pre_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            issued_q   <= issued_d;
            s1_valid_q <= issue;
            s1_idx_q   <= idx_q;
            ts_pend_q  <= ts_pend_d;
            ref_pend_q <= ref_pend_d;
            if (hs) pre_q <= evt_pre_addr_i;
            if (push) wptr_q <= wptr_q + FAW'(1);
            if (pop) rptr_q <= rptr_q + FAW'(1);
            cnt_q <= cnt_q + (FAW+1)'(push) - (FAW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= s1_idx_q;
    end
endmodule

// File: tb/tb_neuron_sweep_ctrl.sv
// tb_neuron_sweep_ctrl: directed bench for neuron_sweep_ctrl with SRAM and neuron models
//
// Runs a 4-neuron core with a 4-deep spike FIFO. SRAMs and a simple integrate-and-fire neuron
// (threshold 64, spike resets state and bumps the count) sit around the DUT; a negedge monitor
// logs reads, writes, handshakes and spike pops with their cycle numbers for later checking.
module tb_neuron_sweep_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        evt_valid = 0, evt_ready, ts_req = 0, ref_req = 0, busy;
    logic [7:0]  evt_pre = 0;
    logic        nrn_re, nrn_we, syn_re;
    logic [1:0]  nrn_raddr, nrn_waddr, spk_addr;
    logic [18:0] nrn_rdata = 0, nrn_wdata;
    logic [9:0]  syn_addr;
    logic [7:0]  syn_rdata = 0, n_syn_weight, wt = 0;
    logic [11:0] n_state_core, n_state_core_next;
    logic [6:0]  n_post_cnt, n_post_cnt_next;
    logic        n_neuron_event, n_time_step_event, n_time_ref_event, n_spike_out;
    logic        spk_valid, spk_ready = 0;
    logic        ld_en = 0;
    logic [1:0]  ld_a = 0;
    logic [18:0] ld_d = 0;
    logic [18:0] mem [4];

    int n_chk = 0, n_err = 0, cyc = 0;
    int rd_n = 0, wr_n = 0, sp_n = 0, hs_n = 0;
    int rd_c [128], wr_c [128], hs_c [16];
    logic [9:0]  rd_sa [128];
    logic        rd_syn [128];
    logic [18:0] wr_d [128];
    logic [1:0]  wr_a [128], sp_a [128];
    logic [2:0]  wr_s [128];

    neuron_sweep_ctrl #(.N_POST(4), .POST_AW(2), .PRE_AW(8), .SPK_FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .evt_valid_i(evt_valid), .evt_ready_o(evt_ready), .evt_pre_addr_i(evt_pre),
        .ts_req_i(ts_req), .ref_req_i(ref_req), .busy_o(busy),
        .nrn_re_o(nrn_re), .nrn_raddr_o(nrn_raddr), .nrn_rdata_i(nrn_rdata),
        .nrn_we_o(nrn_we), .nrn_waddr_o(nrn_waddr), .nrn_wdata_o(nrn_wdata),
        .syn_re_o(syn_re), .syn_addr_o(syn_addr), .syn_rdata_i(syn_rdata),
        .n_state_core_o(n_state_core), .n_post_cnt_o(n_post_cnt), .n_syn_weight_o(n_syn_weight),
        .n_neuron_event_o(n_neuron_event), .n_time_step_event_o(n_time_step_event),
        .n_time_ref_event_o(n_time_ref_event),
        .n_state_core_next_i(n_state_core_next), .n_post_cnt_next_i(n_post_cnt_next),
        .n_spike_out_i(n_spike_out),
        .spk_valid_o(spk_valid), .spk_ready_i(spk_ready), .spk_addr_o(spk_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) mem[ld_a] <= ld_d;
        else if (nrn_we) mem[nrn_waddr] <= nrn_wdata;
        if (nrn_re) nrn_rdata <= mem[nrn_raddr];
        if (syn_re) syn_rdata <= wt;
    end

    always_comb begin
        n_state_core_next = n_state_core;
        n_post_cnt_next   = n_post_cnt;
        n_spike_out       = 1'b0;
        if (n_neuron_event) n_state_core_next = n_state_core + {{4{n_syn_weight[7]}}, n_syn_weight};
        if (n_time_step_event && $signed(n_state_core) >= 12'sd64) begin
            n_spike_out       = 1'b1;
            n_state_core_next = '0;
            n_post_cnt_next   = n_post_cnt + 7'd1;
        end
        if (n_time_ref_event) begin
            n_state_core_next = '0;
            n_post_cnt_next   = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (nrn_re && rd_n < 128) begin
                rd_c[rd_n] = cyc; rd_sa[rd_n] = syn_addr; rd_syn[rd_n] = syn_re; rd_n++;
            end
            if (nrn_we && wr_n < 128) begin
                wr_c[wr_n] = cyc; wr_a[wr_n] = nrn_waddr; wr_d[wr_n] = nrn_wdata;
                wr_s[wr_n] = {n_time_ref_event, n_time_step_event, n_neuron_event}; wr_n++;
            end
            if (spk_valid && spk_ready && sp_n < 128) begin
                sp_a[sp_n] = spk_addr; sp_n++;
            end
            if (evt_valid && evt_ready && hs_n < 16) begin
                hs_c[hs_n] = cyc; hs_n++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c, input logic [18:0] d);
        logic [18:0] v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            ld_en = 1; ld_a = 2'(i); ld_d = v[i];
            tick();
        end
        ld_en = 0;
    endtask

    task automatic pulse(input logic t, input logic r);
        ts_req = t; ref_req = r;
        tick();
        ts_req = 0; ref_req = 0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) tick();
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        int rb, wb, sb, hb, h, rdy;
        repeat (3) tick();
        rst_n = 1;
        @(negedge clk);
        check("rst_evt_ready", evt_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_nrn_we", nrn_we, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_strobes", {n_neuron_event, n_time_step_event, n_time_ref_event}, 0);
        check("rst_wdata", nrn_wdata, 0);
        tick();

        // Event sweep: weights 5 added to zero states, pre index 3.
        load(0, 0, 0, 0);
        wt = 8'd5; rb = rd_n; wb = wr_n; hb = hs_n;
        evt_valid = 1; evt_pre = 8'd3;
        tick();
        evt_valid = 0;
        rdy = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (evt_ready) begin rdy = cyc; break; end
        end
        tick();
        h = hs_c[hb];
        check("evt_reads", rd_n - rb, 4);
        check("evt_writes", wr_n - wb, 4);
        for (int i = 0; i < 4; i++) begin
            check("evt_rd_cyc", rd_c[rb+i] - h, 1 + i);
            check("evt_syn_addr", rd_sa[rb+i], 12 + i);
            check("evt_wr_cyc", wr_c[wb+i] - h, 2 + i);
            check("evt_wr_addr", wr_a[wb+i], i);
            check("evt_wr_data", wr_d[wb+i], 5);
        end
        check("evt_strobe", wr_s[wb], 3'b001);
        check("evt_ready_back", rdy - h, 6);

        // Time step with states {100,10,200,64}: neurons 0,2,3 spike.
        spk_ready = 1;
        load(100, 10, 200, 64);
        rb = rd_n; wb = wr_n; sb = sp_n;
        pulse(1, 0);
        wait_idle(30);
        repeat (3) tick();
        check("ts_spikes", sp_n - sb, 3);
        check("ts_spk0", sp_a[sb], 0);
        check("ts_spk1", sp_a[sb+1], 2);
        check("ts_spk2", sp_a[sb+2], 3);
        check("ts_wd0", wr_d[wb], 19'h01000);
        check("ts_wd1", wr_d[wb+1], 10);
        check("ts_wd2", wr_d[wb+2], 19'h01000);
        check("ts_wd3", wr_d[wb+3], 19'h01000);
        check("ts_strobe", wr_s[wb], 3'b010);
        check("ts_syn_re", rd_syn[rb], 0);

        // FIFO back-pressure: fill 4, then a second sweep must stall until drained.
        spk_ready = 0;
        sb = sp_n;
        load(100, 100, 100, 100);
        pulse(1, 0);
        wait_idle(30);
        check("bp_full_valid", spk_valid, 1);
        load(100, 100, 100, 100);
        rb = rd_n;
        pulse(1, 0);
        repeat (10) tick();
        check("bp_stall_busy", busy, 1);
        check("bp_stall_reads", rd_n - rb, 0);
        spk_ready = 1;
        wait_idle(60);
        repeat (6) tick();
        check("bp_pops", sp_n - sb, 8);
        for (int i = 0; i < 8; i++) check("bp_order", sp_a[sb+i], i % 4);
        check("bp_empty", spk_valid, 0);

        // ts_req during an event sweep while evt_valid stays high.
        load(0, 0, 0, 0);
        rb = rd_n; wb = wr_n; hb = hs_n;
        evt_valid = 1; evt_pre = 8'd1;
        tick();
        tick();
        pulse(1, 0);
        for (int k = 0; k < 60 && hs_n < hb + 2; k++) tick();
        evt_valid = 0;
        wait_idle(30);
        h = hs_c[hb];
        check("mix_hs_count", hs_n - hb, 2);
        check("mix_ts_start", rd_c[rb+4] - h, 7);
        check("mix_hs2", hs_c[hb+1] - h, 12);
        check("mix_s_evt", wr_s[wb+3], 3'b001);
        check("mix_s_ts", wr_s[wb+4], 3'b010);
        check("mix_s_evt2", wr_s[wb+8], 3'b001);
        check("mix_ts_wd", wr_d[wb+4], 5);
        check("mix_evt2_wd", wr_d[wb+8], 10);
        check("mix_syn_addr", rd_sa[rb+8], 4);

        // Simultaneous ref and ts: clear everything first, then evaluate.
        load(19'h03046, 19'h03046, 19'h03046, 19'h03046);
        rb = rd_n; wb = wr_n;
        pulse(1, 1);
        wait_idle(40);
        check("rt_writes", wr_n - wb, 8);
        check("rt_s_ref", wr_s[wb], 3'b100);
        for (int i = 0; i < 4; i++) check("rt_ref_wd", wr_d[wb+i], 0);
        check("rt_s_ts", wr_s[wb+4], 3'b010);
        check("rt_ts_wd", wr_d[wb+7], 0);
        check("rt_syn_re", rd_syn[rb], 0);

        // Reset in the middle of a time-step sweep.
        spk_ready = 0;
        load(100, 100, 100, 100);
        pulse(1, 0);
        tick();
        tick();
        tick();
        @(negedge clk);
        check("ab_pre_valid", spk_valid, 1);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("ab_busy", busy, 0);
        check("ab_spk_valid", spk_valid, 0);
        check("ab_evt_ready", evt_ready, 1);
        check("ab_nrn_we", nrn_we, 0);
        tick();
        tick();
        rst_n = 1;
        tick();
        check("ab_mem0", mem[0], 19'h01000);
        check("ab_mem2", mem[2], 100);
        check("ab_mem3", mem[3], 100);
        check("ab_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
